bin2bcd_seq: RTL and testbench

Iterative binary-to-BCD converter (shift-and-add-3, "double dabble") for the display path. It takes a BIN_W-bit binary value, such as the current LFSR state, and produces DIGITS packed BCD digits for the seven-segment driver. It sequences one correct-then-shift step per clock over a bank of combinational add-3 digit cells, with a start/busy/done handshake.

---
 rtl/bin2bcd_pkg.sv | 21 ++
 rtl/Shift_Add3.sv | 19 +
 rtl/bin2bcd_seq.sv | 102 ++++++++++
 tb/tb_bin2bcd_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and constants for the iterative binary-to-BCD
// converter.
//   state_t   - sequencer states (IDLE / SHIFT / DONE)
//   DIGIT_W   - bits per BCD digit
//   cnt_width - iteration counter width for a given binary input width
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  // The counter must be able to hold 0..bin_w.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/Shift_Add3.sv
// Shift_Add3: combinational add-3 correction for one BCD digit, applied
// before each left shift of the double-dabble algorithm.
//   din  - current digit (0..9 in legal operation)
//   dout - corrected digit: >=5 -> +3, 0..4 unchanged, 10..15 -> 0
module Shift_Add3
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    // Codes 10..15 cannot occur from a legal start; flush them to 0.
    if (din >= DIGIT_W'(10))     dout = '0;
    else if (din >= DIGIT_W'(5)) dout = din + DIGIT_W'(3);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-and-add-3 binary-to-BCD converter.
// One correct-then-shift iteration per clock; BIN_W iterations per value.
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   start   - conversion request, sampled only in IDLE
//   bin_in  - binary value, captured on the accepting edge
//   busy    - high while iterating (BIN_W cycles)
//   done    - one-cycle pulse when bcd_out is updated
//   bcd_out - packed BCD result, units in [3:0], held until next done
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [BIN_W-1:0]            bin_in,
  output logic                        busy,
  output logic                        done,
  output logic [DIGITS*DIGIT_W-1:0]   bcd_out
);

  localparam int CW = cnt_width(BIN_W);
  localparam int DW = DIGITS * DIGIT_W;

  state_t                          state, nstate;
  logic [BIN_W-1:0]                bin_sr;
  logic [DIGITS-1:0][DIGIT_W-1:0]  bcd_sr, bcd_adj;
  logic [DW-1:0]                   adj_flat;
  logic [CW-1:0]                   cnt;
  logic                            last;

  // One add-3 cell per digit of the scratch register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    Shift_Add3 u_add3 (
      .din  (bcd_sr[g]),
      .dout (bcd_adj[g])
    );
  end

  assign adj_flat = bcd_adj;
  assign last     = (cnt == CW'(BIN_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = SHIFT;
      SHIFT:   if (last)  nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs are pure state decodes, so start never reaches done/busy
  // combinationally.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr  <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bin_sr <= bin_in;
          bcd_sr <= '0;
          cnt    <= '0;
        end
        SHIFT: begin
          // Corrected digits and the binary register shift as one word;
          // the top corrected bit falls off (cannot be set under the
          // DIGITS sizing rule).
          {bcd_sr, bin_sr} <= {adj_flat[DW-2:0], bin_sr, 1'b0};
          cnt              <= cnt + 1'b1;
          if (last) bcd_out <= {adj_flat[DW-2:0], bin_sr[BIN_W-1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq. Stimulus pushes the
// decimal-model result for every start it expects to be accepted; a
// negedge monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [BIN_W-1:0]     bin_in = '0;
  logic                 busy, done;
  logic [DIGITS*4-1:0]  bcd_out;

  logic [DIGITS*4-1:0]  exp_q[$];
  int                   n_chk = 0;
  int                   n_fail = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  // Reference: repeated division by ten.
  function automatic logic [DIGITS*4-1:0] to_bcd(input int unsigned v);
    logic [DIGITS*4-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("busy_in_done", 32'(busy), 32'd0);
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_done: got bcd_out %0h expected no done", bcd_out);
      end else begin
        logic [DIGITS*4-1:0] e;
        e = exp_q.pop_front();
        if (bcd_out !== e) begin
          n_fail++;
          $display("FAIL result: got %0h expected %0h", bcd_out, e);
        end
      end
    end
  end

  // One conversion from IDLE. Returns after the DONE cycle, with the DUT
  // back in IDLE for the next call. noisy adds start pulses while busy
  // and during DONE, which must all be ignored.
  task automatic convert(input logic [BIN_W-1:0] v, input bit noisy);
    int lat;
    bit busy_ok;
    bin_in = v;
    start  = 1'b1;
    exp_q.push_back(to_bcd(32'(v)));
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = BIN_W'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      start = noisy && (lat == 3 || lat == 9);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(BIN_W));
    chk("busy_held", 32'(busy_ok), 32'd1);
    if (noisy) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int dones;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed values
    convert(16'd0, 1'b0);
    chk("bcd_0", 32'(bcd_out), 32'h00000);
    convert(16'd65535, 1'b0);
    chk("bcd_65535", 32'(bcd_out), 32'h65535);
    convert(16'd9, 1'b0);
    chk("bcd_9", 32'(bcd_out), 32'h00009);
    convert(16'd10, 1'b1);
    chk("bcd_10", 32'(bcd_out), 32'h00010);
    convert(16'd1234, 1'b1);
    chk("bcd_1234", 32'(bcd_out), 32'h01234);

    // start held high: back-to-back conversions every BIN_W+2 cycles,
    // with bin_in disturbed mid-conversion.
    for (int k = 0; k < 3; k++) exp_q.push_back(to_bcd(4321));
    bin_in = 16'd4321;
    start  = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
        if (lat == 5)  bin_in = 16'd1;
        if (lat == 12) bin_in = 16'd4321;
      end while (!done && lat < 40);
      chk("period", 32'(lat), (k == 0) ? 32'(BIN_W) : 32'(BIN_W + 2));
      if (k == 2) start = 1'b0;
    end
    chk("bcd_4321", 32'(bcd_out), 32'h04321);
    @(posedge clk); #1;

    // Reset abort at E0+7
    bin_in = 16'd500;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    dones = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    convert(16'd500, 1'b0);
    chk("bcd_500", 32'(bcd_out), 32'h00500);

    // Random sweep
    for (int i = 0; i < 1000; i++)
      convert(BIN_W'($urandom_range(0, 65535)), ($urandom_range(0, 3) == 0));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
